shift_reg_unit: RTL
===================

# shift_reg_unit

Holds the two N-bit operand registers A and B of the bit-serial logic processor and sequences an N-cycle serial compute pass. Each shift cycle presents the LSBs of A and B to the 1-bit compute stage. It then routes that stage's returned operand bits and its result bit back into the MSBs of A and B, as selected by the route code R. It also contains the execute control FSM, which runs one pass per Execute press.

## Interface
- N, default 8: register width in bits (N ≥ 2).
- Clk, input, 1: system clock; all state updates on the rising edge.
- Reset, input, 1: synchronous, active-high; overrides every other input.
- LoadA, input, 1: parallel-load Din into A; accepted only in IDLE or HOLD.
- LoadB, input, 1: parallel-load Din into B; accepted only in IDLE or HOLD.
- Execute, input, 1: level request for one serial pass.
- Din, input, N: parallel load data.
- R, input, 2: route select, sampled every SHIFT cycle.
- A_Ret, input, 1: A bit returned by the compute stage.
- B_Ret, input, 1: B bit returned by the compute stage.
- F_A_B, input, 1: result bit from the compute stage.
- A_Shift_Out, output, 1: A[0], combinational from the register, to the compute stage.
- B_Shift_Out, output, 1: B[0], combinational from the register, to the compute stage.
- A_Q, output, N: register A contents, for display.
- B_Q, output, N: register B contents, for display.

## Operation
- FSM states and transitions:
  - IDLE: Execute=1 goes to SHIFT with count cleared to 0.
  - SHIFT: stays for exactly N cycles, then goes to HOLD.
  - HOLD: stays while Execute=1; Execute=0 goes to IDLE.
  - One press of Execute yields exactly one pass, however long it is held.
- Each SHIFT cycle, both registers shift right by one. The new MSBs are set by R:
  - R=00: A←A_Ret, B←B_Ret (operands preserved).
  - R=01: A←A_Ret, B←F_A_B.
  - R=10: A←F_A_B, B←B_Ret.
  - R=11: A←B_Ret, B←A_Ret (swap).
- After N shifts every bit position is aligned again, so the result sits in the routed register in natural bit order.
- Loads:
  - LoadA and LoadB both set: both registers load Din in the same cycle.
  - Loads are ignored in SHIFT; nothing is queued.
  - In IDLE, a load and Execute on the same edge: the load takes effect and the FSM enters SHIFT. The first shift uses the loaded values.
- Counter: $clog2(N+1) bits, increments once per SHIFT cycle, and exits SHIFT when count = N−1 on the clocking edge.
- Reset: A=0, B=0, state=IDLE, count=0. As a result A_Shift_Out=0, B_Shift_Out=0, A_Q=0, B_Q=0.
- Reset asserted mid-SHIFT aborts the pass immediately; partial results are discarded.

## Timing
- Execute sampled high in IDLE at edge k: shifts occur at edges k+1 … k+N, and the state is HOLD after edge k+N.
- Total latency from Execute to result visible on A_Q/B_Q: N+1 cycles.
- A_Shift_Out and B_Shift_Out change only after clock edges. The compute stage is purely combinational, so the return path closes within one cycle with no pipeline register.
- A load takes effect at the next edge; A_Q/B_Q update one cycle after LoadA/LoadB is sampled.

## Configuration
- SHIFT_REG_UNIT_STATUS_EN defined:
  - Adds output Busy (1 in SHIFT) and output Done (one-cycle pulse on the first HOLD cycle).
  - Both reset to 0.
- Not defined: Busy and Done ports are absent; all other behaviour is identical.

## Structure
- Package sru_pkg holds:
  - route_t enum: ROUTE_KEEP=00, ROUTE_B_F=01, ROUTE_A_F=10, ROUTE_SWAP=11.
  - state_t enum: IDLE, SHIFT, HOLD.
  - Default width constant SRU_WIDTH=8.
- Sub-module shift_reg_n, instantiated twice (A and B). It provides synchronous reset, parallel load, right shift with serial MSB input, and parallel out.
- The routing mux and FSM stay in the top module.

## Test plan
Bench connects the compute stage, with N=8.
- Reset after loads with random values -> A_Q=0x00, B_Q=0x00, and no shift occurs on a following Execute until the FSM has returned to IDLE.
- Load A=0x33, B=0x55; F=AND, R=01; Execute -> after 9 cycles A_Q=0x33, B_Q=0x11.
- Load A=0x33, B=0x55; F=XOR, R=10 -> A_Q=0x66, B_Q=0x55.
- Load A=0x33, B=0x55; R=11 -> A_Q=0x55, B_Q=0x33. Hold Execute for 20 cycles -> no second pass; release, press again -> A_Q=0x33, B_Q=0x55.
- Pulse LoadA with Din=0xFF during SHIFT -> ignored, and the pass result is unchanged.
- Assert Reset at shift 4 of 8 -> the next cycle shows A_Q=0, B_Q=0, state IDLE.

Source files
------------

// File: rtl/sru_pkg.sv
// Shared types and constants for the bit-serial operand shift unit.
// Route codes select how returned/result bits re-enter the register MSBs.
package sru_pkg;

   localparam int SRU_WIDTH = 8;

   typedef enum logic [1:0] {
      ROUTE_KEEP = 2'b00,
      ROUTE_B_F  = 2'b01,
      ROUTE_A_F  = 2'b10,
      ROUTE_SWAP = 2'b11
   } route_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      HOLD  = 2'b10
   } state_t;

   // Returns {a_msb, b_msb} for one shift cycle.
   function automatic logic [1:0] route_msbs(
      input route_t route,
      input logic   a_ret,
      input logic   b_ret,
      input logic   f_a_b
   );
      logic [1:0] msbs;
      case (route)
         ROUTE_KEEP: msbs = {a_ret, b_ret};
         ROUTE_B_F:  msbs = {a_ret, f_a_b};
         ROUTE_A_F:  msbs = {f_a_b, b_ret};
         ROUTE_SWAP: msbs = {b_ret, a_ret};
         default:    msbs = {a_ret, b_ret};
      endcase
      return msbs;
   endfunction

endpackage

// File: rtl/shift_reg_n.sv
// N-bit register with synchronous reset, parallel load and right shift
// taking a serial bit into the MSB. Load has priority over shift.
module shift_reg_n
   import sru_pkg::*;
#(
   parameter int N = SRU_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic         ser_in,
   input  logic [N-1:0] din,
   output logic [N-1:0] q
);

   logic [N-1:0] q_r;

   // Register contents: reset, then load, then shift, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r <= '0;
      end else if (load) begin
         q_r <= din;
      end else if (shift) begin
         q_r <= {ser_in, q_r[N-1:1]};
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/shift_reg_unit.sv
// Operand registers A/B plus execute FSM for one N-cycle serial pass.
// Optional Busy/Done status outputs are enabled by SHIFT_REG_UNIT_STATUS_EN.
module shift_reg_unit
   import sru_pkg::*;
#(
   parameter int N = SRU_WIDTH
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         LoadA,
   input  logic         LoadB,
   input  logic         Execute,
   input  logic [N-1:0] Din,
   input  logic [1:0]   R,
   input  logic         A_Ret,
   input  logic         B_Ret,
   input  logic         F_A_B,
   output logic         A_Shift_Out,
   output logic         B_Shift_Out,
   output logic [N-1:0] A_Q,
   output logic [N-1:0] B_Q
`ifdef SHIFT_REG_UNIT_STATUS_EN
   ,
   output logic         Busy,
   output logic         Done
`endif
);

   localparam int CNT_W = $clog2(N + 1);

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_s;
   logic             shift_en_s;
   logic             load_a_s;
   logic             load_b_s;
   logic [1:0]       msbs_s;
   logic [N-1:0]     a_q_s;
   logic [N-1:0]     b_q_s;

   // Next-state and pass counter; the count reaching N-1 marks the last shift.
   always_comb begin
      state_s = state_r;
      count_s = count_r;
      case (state_r)
         IDLE: begin
            if (Execute) begin
               state_s = SHIFT;
               count_s = '0;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            count_s = count_r + CNT_W'(1);
            if (count_r == CNT_W'(N - 1)) begin
               state_s = HOLD;
            end else begin
               state_s = SHIFT;
            end
         end
         HOLD: begin
            if (Execute) begin
               state_s = HOLD;
            end else begin
               state_s = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
            count_s = '0;
         end
      endcase
   end

   // FSM state and counter registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= IDLE;
         count_r <= '0;
      end else begin
         state_r <= state_s;
         count_r <= count_s;
      end
   end

   // Loads are only honoured outside a pass, so nothing can corrupt it.
   assign shift_en_s = (state_r == SHIFT);
   assign load_a_s   = LoadA && !shift_en_s;
   assign load_b_s   = LoadB && !shift_en_s;
   assign msbs_s     = route_msbs(route_t'(R), A_Ret, B_Ret, F_A_B);

   shift_reg_n #(.N(N)) u_reg_a (
      .clk    (Clk),
      .reset  (Reset),
      .load   (load_a_s),
      .shift  (shift_en_s),
      .ser_in (msbs_s[1]),
      .din    (Din),
      .q      (a_q_s)
   );

   shift_reg_n #(.N(N)) u_reg_b (
      .clk    (Clk),
      .reset  (Reset),
      .load   (load_b_s),
      .shift  (shift_en_s),
      .ser_in (msbs_s[0]),
      .din    (Din),
      .q      (b_q_s)
   );

   assign A_Q         = a_q_s;
   assign B_Q         = b_q_s;
   assign A_Shift_Out = a_q_s[0];
   assign B_Shift_Out = b_q_s[0];

`ifdef SHIFT_REG_UNIT_STATUS_EN
   logic busy_r;
   logic done_r;

   // Status flags registered from the next state so they align with state_r.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s == SHIFT);
         done_r <= (state_r == SHIFT) && (state_s == HOLD);
      end
   end

   assign Busy = busy_r;
   assign Done = done_r;
`endif

endmodule
